// File: rtl/stream_rr_arbiter_4.sv
// stream_rr_arbiter_4
// Four-input round-robin arbiter for a ready/valid stream carrying an unsigned
// `data` word and a signed `data2` word. One valid requester is granted per
// cycle. The search starts at the input after the one served last. The winning
// beat is captured in a single output register, so the block is one stage deep
// and can move one beat per cycle.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous active-high reset
//   inN_data/inN_data2       request payload, N = 0..3
//   inN_valid                request valid, N = 0..3
//   inN_ready                grant/accept, combinational, N = 0..3
//   out_data/out_data2       registered payload
//   out_valid                registered valid
//   out_ready                downstream accept
//   out_src                  registered index of the input that supplied out_*
module stream_rr_arbiter_4 #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA2_WIDTH = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in0_data,
    input  logic signed [DATA2_WIDTH-1:0] in0_data2,
    input  logic                          in0_valid,
    output logic                          in0_ready,
    input  logic [DATA_WIDTH-1:0]         in1_data,
    input  logic signed [DATA2_WIDTH-1:0] in1_data2,
    input  logic                          in1_valid,
    output logic                          in1_ready,
    input  logic [DATA_WIDTH-1:0]         in2_data,
    input  logic signed [DATA2_WIDTH-1:0] in2_data2,
    input  logic                          in2_valid,
    output logic                          in2_ready,
    input  logic [DATA_WIDTH-1:0]         in3_data,
    input  logic signed [DATA2_WIDTH-1:0] in3_data2,
    input  logic                          in3_valid,
    output logic                          in3_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic signed [DATA2_WIDTH-1:0] out_data2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    out_src
);

    logic [1:0]                    ptr_r;
    logic [3:0]                    valid_s;
    logic                          any_valid_s;
    logic                          load_s;
    logic                          fire_s;
    logic [1:0]                    grant_s;
    logic [1:0]                    idx_s;
    logic                          found_s;
    logic [DATA_WIDTH-1:0]         sel_data_s;
    logic signed [DATA2_WIDTH-1:0] sel_data2_s;

    assign valid_s     = {in3_valid, in2_valid, in1_valid, in0_valid};
    assign any_valid_s = |valid_s;
    // The output register can take a new beat when it is empty or is being drained this cycle.
    assign load_s      = !out_valid || out_ready;
    // Gating with rst keeps producers from seeing an accept while reset is held.
    assign fire_s      = load_s && any_valid_s && !rst;

    assign in0_ready = fire_s && (grant_s == 2'd0);
    assign in1_ready = fire_s && (grant_s == 2'd1);
    assign in2_ready = fire_s && (grant_s == 2'd2);
    assign in3_ready = fire_s && (grant_s == 2'd3);

    // Priority search: the first valid input in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        grant_s = 2'd0;
        found_s = 1'b0;
        idx_s   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx_s = ptr_r + i[1:0];
            if (!found_s && valid_s[idx_s]) begin
                grant_s = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Payload multiplexer driven by the grant index.
    always_comb begin
        sel_data_s  = in0_data;
        sel_data2_s = in0_data2;
        case (grant_s)
            2'd0: begin
                sel_data_s  = in0_data;
                sel_data2_s = in0_data2;
            end
            2'd1: begin
                sel_data_s  = in1_data;
                sel_data2_s = in1_data2;
            end
            2'd2: begin
                sel_data_s  = in2_data;
                sel_data2_s = in2_data2;
            end
            2'd3: begin
                sel_data_s  = in3_data;
                sel_data2_s = in3_data2;
            end
            default: begin
                sel_data_s  = in0_data;
                sel_data2_s = in0_data2;
            end
        endcase
    end

    // Output register and round-robin pointer. A load takes priority over a plain drain,
    // so that a simultaneous accept and load replaces the beat without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_data2 <= '0;
            out_src   <= 2'd0;
            ptr_r     <= 2'd0;
        end else if (fire_s) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_s;
            out_data2 <= sel_data2_s;
            out_src   <= grant_s;
            ptr_r     <= grant_s + 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter_4.sv
module tb_stream_rr_arbiter_4;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       d  [4];
    logic signed [12:0] d2 [4];
    logic [3:0]        v;
    logic [3:0]        rdy;
    logic [15:0]       out_data;
    logic signed [12:0] out_data2;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_src;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_ptr;
    bit          m_valid;
    logic [15:0] m_data;
    logic [12:0] m_data2;
    int          m_src;
    bit          acc [4];

    always #5 clk = ~clk;

    stream_rr_arbiter_4 dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (d[0]), .in0_data2 (d2[0]), .in0_valid (v[0]), .in0_ready (rdy[0]),
        .in1_data  (d[1]), .in1_data2 (d2[1]), .in1_valid (v[1]), .in1_ready (rdy[1]),
        .in2_data  (d[2]), .in2_data2 (d2[2]), .in2_valid (v[2]), .in2_ready (rdy[2]),
        .in3_data  (d[3]), .in3_data2 (d2[3]), .in3_valid (v[3]), .in3_ready (rdy[3]),
        .out_data  (out_data),
        .out_data2 (out_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_data2 = 13'h0000;
        m_src   = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".data"},  {16'd0, out_data},  {16'd0, m_data});
        chk({tag, ".data2"}, {19'd0, out_data2}, {19'd0, m_data2});
        chk({tag, ".src"},   {30'd0, out_src},   m_src);
    endtask

    // One clock: check readies against the model mid-cycle, let the edge pass,
    // advance the model by the transfer rules and compare the output register.
    task automatic cycle(input string tag);
        int  g;
        bit  load;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
        load = !m_valid || out_ready;
        for (int n = 0; n < 4; n++) begin
            acc[n] = load && (g == n) && !rst;
            chk({tag, ".ready"}, {31'd0, rdy[n]}, {31'd0, acc[n]});
        end
        @(posedge clk);
        #1;
        if (load && g >= 0) begin
            m_valid = 1'b1;
            m_data  = d[g];
            m_data2 = d2[g];
            m_src   = g;
            m_ptr   = (g + 1) % 4;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1;
        v = 4'b0000;
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            d[n]  = 16'h0000;
            d2[n] = 13'sd0;
        end
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.ready", {28'd0, rdy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // idle
        out_ready = 1'b1;
        cycle("idle");
        cycle("idle");

        // round-robin fairness with all inputs requesting
        for (int n = 0; n < 4; n++) begin
            d[n]  = 16'h1000 + 16'(n);
            d2[n] = 13'(n * 100 - 200);
        end
        v = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle("fair");
            chk("fair.src_seq", {30'd0, out_src}, i % 4);
            chk("fair.data_seq", {16'd0, out_data}, 32'h1000 + (i % 4));
        end

        // skip and wrap: grant input 2, then only 1 and 3 request
        v = 4'b0100;
        cycle("skip.g2");
        chk("skip.src2", {30'd0, out_src}, 32'd2);
        v = 4'b1010;
        cycle("skip.g3");
        chk("skip.src3", {30'd0, out_src}, 32'd3);
        v = 4'b0010;
        cycle("skip.g1");
        chk("skip.src1", {30'd0, out_src}, 32'd1);
        v = 4'b0000;
        cycle("skip.drain");

        // backpressure
        v[0] = 1'b1;
        d[0] = 16'hAAAA;
        d2[0] = 13'sd77;
        out_ready = 1'b0;
        cycle("bp.load");
        d[0] = 16'hBBBB;
        d2[0] = -13'sd5;
        for (int i = 0; i < 5; i++) begin
            cycle("bp.hold");
            chk("bp.held", {16'd0, out_data}, 32'h0000AAAA);
            chk("bp.noready", {28'd0, rdy}, 32'd0);
        end
        out_ready = 1'b1;
        cycle("bp.swap");
        chk("bp.next", {16'd0, out_data}, 32'h0000BBBB);
        chk("bp.next_valid", {31'd0, out_valid}, 32'd1);
        v[0] = 1'b0;
        cycle("bp.drain");
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // signed passthrough on input 1
        v = 4'b0010;
        d[1] = 16'hFFFF;
        d2[1] = -13'sd4096;
        cycle("sgn.a");
        chk("sgn.neg_min", {19'd0, out_data2}, 32'h1000);
        d2[1] = 13'sd4095;
        cycle("sgn.b");
        chk("sgn.pos_max", {19'd0, out_data2}, 32'h0FFF);
        d2[1] = -13'sd1;
        cycle("sgn.c");
        chk("sgn.minus1", {19'd0, out_data2}, 32'h1FFF);
        chk("sgn.src", {30'd0, out_src}, 32'd1);
        v = 4'b0000;
        cycle("sgn.drain");

        // single requester at full rate
        v = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            d[3]  = 16'h3000 + 16'(i);
            d2[3] = 13'(i);
            cycle("solo");
            chk("solo.valid", {31'd0, out_valid}, 32'd1);
            chk("solo.src", {30'd0, out_src}, 32'd3);
            chk("solo.data", {16'd0, out_data}, 32'h3000 + i);
        end
        v = 4'b0000;
        cycle("solo.drain");

        // randomized traffic with random backpressure
        for (int n = 0; n < 4; n++) acc[n] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            for (int n = 0; n < 4; n++) begin
                if (acc[n] || !v[n]) begin
                    v[n]  = ($urandom_range(0, 3) != 0);
                    d[n]  = 16'($urandom);
                    d2[n] = 13'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        // reset in the middle of a stream
        v = 4'b1111;
        out_ready = 1'b1;
        cycle("mid.fill");
        chk("mid.full", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid.rst");
        chk("mid.noready", {28'd0, rdy}, 32'd0);
        @(negedge clk);
        v = 4'b0000;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("mid.idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter_4.md
# stream_rr_arbiter_4

Four-input round-robin arbiter for the ready/valid stream interface carrying `data` (unsigned, 16 bit) and `data2` (signed, 13 bit). It shares one downstream consumer between four producers. It picks one valid requester per cycle, starting the search from the input after the last one served. The winning beat goes into a single output register, so the block is one pipeline stage deep, runs at full throughput and reports which input each beat came from.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `data` (unsigned).
- `DATA2_WIDTH`, 13: width of `data2` (signed, two's complement, passed through unmodified).

Ports:
- `clk`  input  1  single clock; everything is on its rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `inN_data`  input  DATA_WIDTH  request payload, for N = 0..3.
- `inN_data2`  input  signed DATA2_WIDTH  request payload, for N = 0..3.
- `inN_valid`  input  1  request valid, for N = 0..3.
- `inN_ready`  output  1  grant/accept, for N = 0..3; combinational.
- `out_data`  output  DATA_WIDTH  registered payload.
- `out_data2`  output  signed DATA2_WIDTH  registered payload.
- `out_valid`  output  1  registered valid.
- `out_ready`  input  1  downstream accept.
- `out_src`  output  2  index of the input that supplied the current output beat; registered.

## Operation
- Transfer rules:
  - A transfer on any port happens in a cycle where valid and ready are both 1 at the rising edge.
  - Producers hold valid and payload stable until accepted.
  - The arbiter never drops or duplicates a beat.
- Load enable: `load = !out_valid || out_ready`.
- Round-robin pointer `ptr[1:0]`:
  - Holds the highest-priority input for the current cycle.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - The grant `g` is the first input in that order with valid=1.
- `inN_ready = load && (N == g) && any_valid && !rst`. At most one ready is high in any cycle.
- On a granted transfer:
  - The output register captures `in[g]` data and data2 bit-exact (no sign or width change).
  - `out_src` takes g and `out_valid` is set to 1.
  - `ptr` becomes g+1 mod 4; 3 wraps to 0.
- Output accepted with no new grant: `out_valid` goes to 0. Data and `out_src` keep their last values.
- No valid input: `ptr` does not change.
- The grant is recomputed every cycle. A producer that is waiting is not locked in, but fairness holds: any input that stays valid is served within 4 grants.
- Simultaneous accept and load: when `out_valid=1`, `out_ready=1` and an input is granted in the same cycle, the old beat leaves and the new beat loads. No bubble is allowed.
- Backpressure: when `out_valid=1` and `out_ready=0`, all `inN_ready` are 0 and the output register holds.
- No state machine beyond `ptr` and the output register. The two states are EMPTY (`out_valid=0`) and FULL (`out_valid=1`), with transitions as above.

## Timing
- Reset values, applied immediately on rst assertion without waiting for a clock edge: `out_valid=0`, `out_data=0`, `out_data2=0`, `out_src=0`, `ptr=0`.
- All `inN_ready` are 0 while rst is high.
- Reset in the middle of a transfer: any beat held in the output register is discarded. Producers see no accept in cycles where rst is high.
- Latency: a beat accepted at edge k appears on `out_*` right after edge k and can be consumed at edge k+1.
- Throughput: one beat per cycle whenever requests are continuous and `out_ready=1`.
- Combinational paths:
  - `inN_valid` to `inN_ready` (through the priority search).
  - `out_ready` to `inN_ready`.
- No combinational path from any input to `out_*`.

## Test plan
- Reset and idle:
  - Assert rst mid-stream with `out_valid=1`.
  - Required: `out_valid`, `out_data`, `out_data2` and `out_src` read 0 before the next edge. All readies are 0.
  - After release with no valid inputs, `out_valid` stays 0.
- Round-robin fairness:
  - All four inputs hold valid with data 0x1000+N, `out_ready=1` continuously.
  - Required: `out_src` sequence 0,1,2,3,0,1…, one beat per cycle, data matching its source.
- Skip and wrap:
  - After a grant to input 2, only in1 and in3 are valid.
  - Required: in3 is served next, then in1 (pointer wraps 3 to 0 and skips in0).
- Backpressure:
  - Hold `out_ready=0` for 5 cycles with in0 valid.
  - Required: every `inN_ready` is 0 and the output is stable at the first beat.
  - On `out_ready=1`, the held beat and the next one transfer on consecutive edges with no bubble.
- Signed passthrough:
  - in1 sends data2 of -4096, 4095 and -1 with data 0xFFFF.
  - Required: `out_data2` shows the identical signed values (13'h1000, 13'h0FFF, 13'h1FFF) and `out_src=1`.
- Single requester at full rate:
  - in3 alone streams 8 beats, `out_ready=1`.
  - Required: 8 beats in 8 consecutive cycles, all with `out_src=3`.
